// File: rtl/dp_pkg.sv
// Shared definitions for the datapath instruction sequencer: instruction
// layout, field positions and FSM state encoding.
package dp_pkg;

    localparam int OPC_W   = 3;
    localparam int RA_W    = 2;
    localparam int RPT_W   = 2;
    localparam int INSTR_W = 11;

    localparam int OPC_LSB = 8;
    localparam int WA_LSB  = 6;
    localparam int RA1_LSB = 4;
    localparam int RA2_LSB = 2;
    localparam int RPT_LSB = 0;

    // Member order mirrors the packed word: [10:8] opcode ... [1:0] rpt.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [RA_W-1:0]  wa;
        logic [RA_W-1:0]  ra1;
        logic [RA_W-1:0]  ra2;
        logic [RPT_W-1:0] rpt;
    } dp_instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } dp_state_e;

endpackage

// File: rtl/dp_instr_fifo.sv
// Synchronous show-ahead FIFO holding queued instruction words.
// clr empties it at the clock edge and takes priority over push/pop.
module dp_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [AW:0]  level_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign push_ok_s = push && !full && !clr;
    assign pop_ok_s  = pop && !empty && !clr;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + PTR_ONE;
                2'b01:   level_r <= level_r - PTR_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = (level_r == FULL_LVL);
    assign empty = (level_r == '0);
    assign level = level_r;

endmodule

// File: rtl/dp_sequencer.sv
// Instruction sequencer: queues packed ALU instructions and issues each as
// READ/WRITE cycle pairs, repeated rpt+1 times, to the datapath controls.
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               flush,
    output logic               dp_we,
    output logic [RA_W-1:0]    dp_ra1,
    output logic [RA_W-1:0]    dp_ra2,
    output logic [RA_W-1:0]    dp_wa,
    output logic [OPC_W-1:0]   dp_opcode,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   exec_count,
    output logic [LVL_W-1:0]   fifo_level
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RPT_W-1:0] RPT_ONE = {{(RPT_W-1){1'b0}}, 1'b1};

    dp_state_e          state_r;
    dp_state_e          state_nx_s;
    logic [RPT_W-1:0]   rep_cnt_r;
    logic [RPT_W-1:0]   rep_cnt_nx_s;
    logic               pop_s;
    logic               push_s;
    logic               done_nx_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [INSTR_W-1:0] fifo_dout_s;
    dp_instr_t          head_s;

    assign instr_ready = !fifo_full_s && !flush;
    assign push_s      = instr_valid && instr_ready;
    assign head_s      = fifo_dout_s;

    dp_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .clr   (flush),
        .din   (instr_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Next-state, repeat counter and pop decisions; flush beats any pop.
    always_comb begin
        state_nx_s   = state_r;
        rep_cnt_nx_s = rep_cnt_r;
        pop_s        = 1'b0;
        done_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !flush) begin
                    pop_s        = 1'b1;
                    rep_cnt_nx_s = head_s.rpt;
                    state_nx_s   = ST_READ;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_READ: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else if (rep_cnt_r != '0) begin
                    rep_cnt_nx_s = rep_cnt_r - RPT_ONE;
                    state_nx_s   = ST_READ;
                end else begin
                    done_nx_s = 1'b1;
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        rep_cnt_nx_s = head_s.rpt;
                        state_nx_s   = ST_READ;
                    end else begin
                        state_nx_s   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, registered controls, field latches and the commit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rep_cnt_r  <= '0;
            dp_we      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            exec_count <= '0;
            dp_opcode  <= '0;
            dp_wa      <= '0;
            dp_ra1     <= '0;
            dp_ra2     <= '0;
        end else begin
            state_r   <= state_nx_s;
            rep_cnt_r <= rep_cnt_nx_s;
            dp_we     <= (state_nx_s == ST_WRITE);
            busy      <= (state_nx_s != ST_IDLE);
            done      <= done_nx_s;
            // A WRITE cycle always commits, even when flush arrives with it.
            if (state_r == ST_WRITE) begin
                exec_count <= exec_count + CNT_ONE;
            end else begin
                exec_count <= exec_count;
            end
            if (pop_s) begin
                dp_opcode <= head_s.opcode;
                dp_wa     <= head_s.wa;
                dp_ra1    <= head_s.ra1;
                dp_ra2    <= head_s.ra2;
            end else begin
                dp_opcode <= dp_opcode;
                dp_wa     <= dp_wa;
                dp_ra1    <= dp_ra1;
                dp_ra2    <= dp_ra2;
            end
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: a queue-based reference of the instruction stream
// checked every cycle, plus hand-computed checks on directed scenarios.
module tb_dp_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [10:0]   instr_data;
    logic          flush;
    logic          dp_we;
    logic [1:0]    dp_ra1;
    logic [1:0]    dp_ra2;
    logic [1:0]    dp_wa;
    logic [2:0]    dp_opcode;
    logic          busy;
    logic          done;
    logic [CW-1:0] exec_count;
    logic [2:0]    fifo_level;

    dp_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .flush(flush), .dp_we(dp_we), .dp_ra1(dp_ra1),
        .dp_ra2(dp_ra2), .dp_wa(dp_wa), .dp_opcode(dp_opcode), .busy(busy),
        .done(done), .exec_count(exec_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: pending queue, current instruction and its cycle index k
    // (k counts 0 .. 2*(rpt+1)-1; odd k are write cycles).
    logic [10:0]   mq[$];
    bit            m_act;
    logic [10:0]   m_cur;
    int            m_k;
    logic [CW-1:0] m_cnt;
    bit            m_done;

    task automatic model_reset();
        mq.delete();
        m_act  = 1'b0;
        m_cur  = 11'd0;
        m_k    = 0;
        m_cnt  = '0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        bit push_ok;
        int len;
        push_ok = instr_valid && (mq.size() < DEPTH) && !flush;
        m_done  = 1'b0;
        if (m_act && (m_k % 2 == 1)) m_cnt = m_cnt + 1'b1;
        if (flush) begin
            mq.delete();
            m_act = 1'b0;
        end else begin
            if (m_act) begin
                len = 2 * (int'(m_cur[1:0]) + 1);
                if (m_k == len - 1) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_k = m_k + 1;
                end
            end
            if (!m_act && mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_k   = 0;
                m_act = 1'b1;
            end
            if (push_ok) mq.push_back(instr_data);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("dp_we", 32'(dp_we), 32'(m_act && (m_k % 2 == 1)));
        chk("busy", 32'(busy), 32'(m_act));
        chk("done", 32'(done), 32'(m_done));
        chk("dp_opcode", 32'(dp_opcode), 32'(m_cur[10:8]));
        chk("dp_wa", 32'(dp_wa), 32'(m_cur[7:6]));
        chk("dp_ra1", 32'(dp_ra1), 32'(m_cur[5:4]));
        chk("dp_ra2", 32'(dp_ra2), 32'(m_cur[3:2]));
        chk("exec_count", 32'(exec_count), 32'(m_cnt));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("instr_ready", 32'(instr_ready), 32'((mq.size() < DEPTH) && !flush));
    endtask

    task automatic step(input bit v, input logic [10:0] d, input bit f, output bit acc);
        instr_valid = v;
        instr_data  = d;
        flush       = f;
        #1;
        acc = v && instr_ready;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_step();
        bit a;
        step(1'b0, 11'd0, 1'b0, a);
    endtask

    task automatic wait_phase(input bit want_wr, input int minq, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (m_act && ((m_k % 2 == 1) == want_wr) && mq.size() >= minq) begin
                ok = 1'b1;
                break;
            end
            idle_step();
        end
    endtask

    task automatic check_reset_values();
        chk("rst_dp_we", 32'(dp_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_exec_count", 32'(exec_count), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_fields", 32'({dp_opcode, dp_wa, dp_ra1, dp_ra2}), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    endtask

    initial begin
        bit          acc;
        bit          ok;
        bit          saw_full;
        int          pushed;
        int          busy_n;
        int          we_n;
        int          done_n;
        logic [7:0]  pat;
        logic [10:0] w;

        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr_data = 11'd0;
        flush = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Single op: opc=0 wa=2 ra1=0 ra2=1 rpt=0.
        step(1'b1, 11'b000_10_00_01_00, 1'b0, acc);
        chk("single_level", 32'(fifo_level), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);
        idle_step();
        chk("single_read_we", 32'(dp_we), 32'd0);
        chk("single_read_busy", 32'(busy), 32'd1);
        idle_step();
        chk("single_write_we", 32'(dp_we), 32'd1);
        chk("single_write_wa", 32'(dp_wa), 32'd2);
        chk("single_write_ra2", 32'(dp_ra2), 32'd1);
        idle_step();
        chk("single_done", 32'(done), 32'd1);
        chk("single_we_off", 32'(dp_we), 32'd0);
        chk("single_count", 32'(exec_count), 32'd1);
        idle_step();
        chk("single_done_pulse", 32'(done), 32'd0);

        // Repeat: rpt=3 gives four READ/WRITE pairs.
        step(1'b1, 11'b101_01_11_10_11, 1'b0, acc);
        pat = 8'd0;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            idle_step();
            pat = {pat[6:0], dp_we};
            done_n += int'(done);
            chk("rpt_opcode", 32'(dp_opcode), 32'd5);
            chk("rpt_wa", 32'(dp_wa), 32'd1);
        end
        chk("rpt_we_pattern", 32'(pat), 32'h55);
        idle_step();
        done_n += int'(done);
        chk("rpt_done_count", 32'(done_n), 32'd1);
        chk("rpt_count", 32'(exec_count), 32'd5);

        // Back-to-back: five rpt=1 words with valid held high.
        saw_full = 1'b0;
        pushed = 0;
        busy_n = 0;
        we_n = 0;
        for (int c = 0; c < 40 && pushed < 5; c++) begin
            w = {3'(pushed), 2'(pushed), 2'(pushed + 1), 2'(pushed + 2), 2'b01};
            step(1'b1, w, 1'b0, acc);
            if (acc) pushed++;
            if (!instr_ready) saw_full = 1'b1;
            busy_n += int'(busy);
            we_n += int'(dp_we);
        end
        chk("b2b_pushed", 32'(pushed), 32'd5);
        chk("b2b_saw_full", 32'(saw_full), 32'd1);
        for (int c = 0; c < 30; c++) begin
            idle_step();
            busy_n += int'(busy);
            we_n += int'(dp_we);
        end
        chk("b2b_busy_cycles", 32'(busy_n), 32'd20);
        chk("b2b_writes", 32'(we_n), 32'd10);
        chk("b2b_count", 32'(exec_count), 32'd15);

        // Flush in READ of a rpt=2 instruction with two words queued.
        step(1'b1, 11'b011_00_01_10_10, 1'b0, acc);
        step(1'b1, 11'b001_01_01_01_00, 1'b0, acc);
        step(1'b1, 11'b010_10_10_10_00, 1'b0, acc);
        wait_phase(1'b0, 2, ok);
        chk("flushr_reached", 32'(ok), 32'd1);
        step(1'b0, 11'd0, 1'b1, acc);
        chk("flushr_level", 32'(fifo_level), 32'd0);
        chk("flushr_busy", 32'(busy), 32'd0);
        chk("flushr_we", 32'(dp_we), 32'd0);
        chk("flushr_count", 32'(exec_count), 32'd0);
        idle_step();
        chk("flushr_no_done", 32'(done), 32'd0);

        // Flush in WRITE together with a push that must be dropped.
        step(1'b1, 11'b110_11_10_01_01, 1'b0, acc);
        step(1'b1, 11'b100_00_11_11_00, 1'b0, acc);
        wait_phase(1'b1, 1, ok);
        chk("flushw_reached", 32'(ok), 32'd1);
        step(1'b1, 11'b111_11_11_11_11, 1'b1, acc);
        chk("flushw_count", 32'(exec_count), 32'd1);
        chk("flushw_busy", 32'(busy), 32'd0);
        chk("flushw_level", 32'(fifo_level), 32'd0);
        idle_step();
        chk("flushw_no_done", 32'(done), 32'd0);
        chk("flushw_dropped", 32'(fifo_level), 32'd0);

        // Randomised traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 11'($urandom), ($urandom_range(0, 31) == 0), acc);
        end
        for (int c = 0; c < 40; c++) idle_step();

        // Asynchronous reset in the middle of a WRITE cycle.
        step(1'b1, 11'b011_10_01_11_11, 1'b0, acc);
        wait_phase(1'b1, 0, ok);
        chk("areset_reached", 32'(ok), 32'd1);
        chk("areset_we_before", 32'(dp_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Counter wrap: 16 writes on a 4-bit counter land back on zero.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, {3'(i), 2'(i), 2'(3 - i), 2'(i), 2'b11}, 1'b0, acc);
        end
        for (int c = 0; c < 40; c++) idle_step();
        chk("wrap_count", 32'(exec_count), 32'd0);
        chk("wrap_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Instruction sequencer for the 8-bit ALU/RegFile datapath.
- Accepts packed register-to-register ALU instructions over a valid/ready handshake and buffers them in a small FIFO.
- Issues each instruction to the datapath as a two-cycle READ/WRITE sequence, repeated 1-4 times per instruction, so iterative operations need one instruction word (e.g. R0 <= R0+R1 four times).
- Sits between the instruction source (testbench or future fetch unit) and the datapath control inputs.

Parameters:
- FIFO_DEPTH, 4, instruction FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word offered.
- instr_ready  out  1  FIFO can accept; a push occurs when instr_valid and instr_ready are both high at a clock edge.
- instr_data  in  11  packed instruction: [10:8] opcode, [7:6] wa, [5:4] ra1, [3:2] ra2, [1:0] rpt; executes rpt+1 times.
- flush  in  1  synchronous abort: empties the FIFO and cancels the current instruction.
- dp_we  out  1  datapath register write enable.
- dp_ra1  out  2  datapath read address 1.
- dp_ra2  out  2  datapath read address 2.
- dp_wa  out  2  datapath write address.
- dp_opcode  out  3  datapath ALU opcode.
- busy  out  1  high in READ or WRITE.
- done  out  1  one-cycle pulse in the cycle after the final WRITE of an instruction.
- exec_count  out  CNT_W  number of committed writes (WRITE cycles); wraps modulo 2^CNT_W.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): all outputs are 0 except instr_ready, which is 1. FIFO is empty and the FSM is in IDLE.
- All dp_* outputs are registered. dp_ra1, dp_ra2, dp_wa and dp_opcode hold the current instruction fields, stable across READ and WRITE. In IDLE they hold their last values.
- instr_ready = !full && !flush. Push is never bypassed into execution: an accepted word is always written to the FIFO first.
- FSM states:
  - IDLE: if FIFO non-empty and !flush, pop, load the fields, set rep_cnt=rpt, go to READ.
  - READ: dp_we=0; operands settle through the ALU. Next state is WRITE.
  - WRITE: dp_we=1; the RegFile commits at the end of this cycle, and exec_count increments at the same edge.
    - If rep_cnt!=0: decrement it, go to READ.
    - Else assert done next cycle. If FIFO non-empty, pop and go to READ with new fields (no IDLE bubble). Otherwise go to IDLE.
- Throughput: 2*(rpt+1) cycles per instruction.
- Latency: push at edge N into an empty idle FIFO → pop at edge N+1 → READ in cycle N+1, WRITE in cycle N+2, done in cycle N+3.
- Simultaneous push and pop are permitted when not full; fifo_level is unchanged in that case.
- Full: instr_ready=0; input is ignored until a pop.
- flush:
  - FIFO cleared at the edge; any push in the same cycle is dropped.
  - In READ: go to IDLE, no write, no done.
  - In WRITE: dp_we is already high, so the write commits and exec_count increments. Then go to IDLE with no further repeats and no done.
  - Flush has priority over pop.
- Reset mid-operation: dp_we drops immediately (asynchronously), the pending write is lost, and the FIFO is cleared.
- exec_count wraps from all-ones to 0 with no flag.

Decomposition:
- Shared package dp_pkg:
  - field positions and widths: OPC_W=3, RA_W=2, RPT_W=2, INSTR_W=11;
  - FSM state encoding: IDLE/READ/WRITE;
  - instruction field-extract constants.
- One sub-module, dp_instr_fifo: a parameterised synchronous FIFO.
  - Ports: clk, rst_n, push, pop, clr, din, dout, full, empty, level.
  - Show-ahead dout.

Test Plan:
- Single op: push {opc=0,wa=2,ra1=0,ra2=1,rpt=0} into an idle block → dp_we high exactly one cycle, on cycle N+2; dp_wa=2; done on N+3; exec_count=1.
- Repeat: push rpt=3 → dp_we pattern 0,1,0,1,0,1,0,1 over 8 cycles; fields constant throughout; one done; exec_count=4.
- Back-to-back: push 5 instructions with valid held high → instr_ready low once fifo_level=4. All 5 execute with no IDLE cycles between them; exec_count=5.
- Flush in READ of a rpt=2 instruction with 2 queued → no write; fifo_level=0; FSM in IDLE; exec_count unchanged; no done.
- Flush in WRITE → that write still commits (exec_count +1); next cycle IDLE; no done; a push in the same cycle is dropped.
- Async reset asserted mid-WRITE → dp_we=0 and all outputs at reset values before the next edge. exec_count wrap check: preload with CNT_W=4, perform 16 writes → count returns to 0.
